// File: rtl/mlb_loader_if.sv
// Bus bundle between a stream source / controller and the MLB loader.
// The master side drives start, configuration and the word stream; the slave side is the loader.
interface mlb_loader_if;
    logic         i_start;
    logic [4:0]   i_base_sel;
    logic [5:0]   i_num_lines;
    logic         i_s_valid;
    logic [31:0]  i_s_data;
    logic         i_s_last;
    logic         o_s_ready;
    logic         o_write_en;
    logic [4:0]   o_sel_pe;
    logic [511:0] o_line_data;
    logic         o_busy;
    logic         o_done;

    modport master (
        output i_start, i_base_sel, i_num_lines, i_s_valid, i_s_data, i_s_last,
        input  o_s_ready, o_write_en, o_sel_pe, o_line_data, o_busy, o_done
    );

    modport slave (
        input  i_start, i_base_sel, i_num_lines, i_s_valid, i_s_data, i_s_last,
        output o_s_ready, o_write_en, o_sel_pe, o_line_data, o_busy, o_done
    );
endinterface

// File: rtl/mlb_loader.sv
// Gathers 16-word lines from a 32-bit stream and writes them into consecutive MLB PE slots.
// Optional MLB_LOADER_PAD_EN: s_last zero-fills the current line, writes it and ends the load.
module mlb_loader (
    input  logic         clk,
    input  logic         rst_n,
    mlb_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_base;
    logic [5:0]  r_num;
    logic [5:0]  r_line_cnt;
    logic [3:0]  r_word_cnt;
    logic        r_pad_end;
    logic        w_accept;
    logic        w_pad_last;
    logic        w_line_full;
    logic [5:0]  w_num_sat;

    assign w_accept  = bus.i_s_valid && (r_state == FILL);
    assign w_num_sat = (bus.i_num_lines > 6'd32) ? 6'd32 : bus.i_num_lines;

`ifdef MLB_LOADER_PAD_EN
    assign w_pad_last = w_accept && bus.i_s_last;
`else
    logic w_unused_last;
    assign w_unused_last = bus.i_s_last;
    assign w_pad_last    = 1'b0;
`endif

    assign w_line_full = w_accept && ((r_word_cnt == 4'd15) || w_pad_last);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (bus.i_start) w_state_next = (w_num_sat == 6'd0) ? DONE : FILL;
            FILL:  if (w_line_full) w_state_next = WRITE;
            WRITE: w_state_next = (r_pad_end || (r_line_cnt + 6'd1 == r_num)) ? DONE : FILL;
            DONE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_num      <= '0;
            r_line_cnt <= '0;
            r_word_cnt <= '0;
            r_pad_end  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: if (bus.i_start) begin
                    r_base     <= bus.i_base_sel;
                    r_num      <= w_num_sat;
                    r_line_cnt <= '0;
                    r_word_cnt <= '0;
                    r_pad_end  <= 1'b0;
                end
                FILL: if (w_accept) begin
                    // Wrapping 15 -> 0 here is harmless: WRITE clears it anyway.
                    r_word_cnt <= r_word_cnt + 4'd1;
                    if (w_pad_last) r_pad_end <= 1'b1;
                end
                WRITE: begin
                    r_line_cnt <= r_line_cnt + 6'd1;
                    r_word_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Each slot keeps its word across lines; only an accepted word or a pad fill changes it.
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
        logic [31:0] r_word;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_word <= '0;
            end else if (w_accept && (r_word_cnt == 4'(gi))) begin
                r_word <= bus.i_s_data;
            end else if (w_pad_last && (4'(gi) > r_word_cnt)) begin
                r_word <= '0;
            end
        end
        assign bus.o_line_data[32*gi +: 32] = r_word;
    end

    assign bus.o_s_ready  = (r_state == FILL);
    assign bus.o_write_en = (r_state == WRITE);
    assign bus.o_done     = (r_state == DONE);
    assign bus.o_busy     = (r_state != IDLE);
    assign bus.o_sel_pe   = r_base + r_line_cnt[4:0];
endmodule

// File: tb/tb_mlb_loader.sv
// Directed bench for mlb_loader: back-to-back, wrap, zero lines, throttled stream, s_last, saturation, mid-load reset.
module tb_mlb_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mlb_loader_if bus ();
    mlb_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef MLB_LOADER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [4:0]   wr_sel[$];
    logic [511:0] wr_data[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_write_en) begin
                wr_sel.push_back(bus.o_sel_pe);
                wr_data.push_back(bus.o_line_data);
                $display("write: sel_pe=%0d line_data=%h", bus.o_sel_pe, bus.o_line_data);
            end
            if (bus.o_done) begin
                done_cnt++;
                $display("done pulse");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_start     = 1'b0;
        bus.i_base_sel  = '0;
        bus.i_num_lines = '0;
        bus.i_s_valid   = 1'b0;
        bus.i_s_data    = '0;
        bus.i_s_last    = 1'b0;
    endtask

    task automatic clear_log();
        wr_sel.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic launch(input logic [4:0] base, input logic [5:0] lines);
        bus.i_start     = 1'b1;
        bus.i_base_sel  = base;
        bus.i_num_lines = lines;
        tick();
        bus.i_start     = 1'b0;
    endtask

    function automatic logic [511:0] seq_line(input int first);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = 32'(first + k);
        return v;
    endfunction

    // Streams n words first..first+n-1; also checks write_en appears right after each 16th (or padded last) word.
    task automatic stream(input int first, input int n, input bit toggle, input int last_idx, input bit poke);
        int idx;
        int cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 2000) begin
            bus.i_s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.i_s_data  = 32'(first + idx);
            bus.i_s_last  = (idx == last_idx);
            bus.i_start   = poke && (cyc == 3);
            if (poke && cyc == 3) begin
                bus.i_base_sel  = 5'd20;
                bus.i_num_lines = 6'd5;
            end
            acc = bus.i_s_valid && bus.o_s_ready;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if ((idx % 16) == 0 || (PAD && (idx - 1) == last_idx)) begin
                    n_cmp++;
                    if (bus.o_write_en !== 1'b1) begin
                        n_err++;
                        $display("FAIL write_latency word %0d: write_en=%b expected 1", idx, bus.o_write_en);
                    end
                end
            end
        end
        n_cmp++;
        if (idx < n) begin
            n_err++;
            $display("FAIL stream_timeout: accepted %0d expected %0d", idx, n);
        end
        idle_inputs();
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (bus.o_busy && c < 100) begin
            tick();
            c++;
        end
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b expected 0", bus.o_busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp += 6;
        if (bus.o_s_ready !== 1'b0)  begin n_err++; $display("FAIL reset_s_ready: got %b expected 0", bus.o_s_ready); end
        if (bus.o_write_en !== 1'b0) begin n_err++; $display("FAIL reset_write_en: got %b expected 0", bus.o_write_en); end
        if (bus.o_done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.o_done); end
        if (bus.o_busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
        if (bus.o_sel_pe !== 5'd0)   begin n_err++; $display("FAIL reset_sel_pe: got %0d expected 0", bus.o_sel_pe); end
        if (bus.o_line_data !== '0)  begin n_err++; $display("FAIL reset_line_data: got %h expected 0", bus.o_line_data); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        launch(5'd3, 6'd2);
        stream(0, 32, 1'b0, -1, 1'b0);
        wait_idle();
        n_cmp += 2;
        if (wr_sel.size() !== 2) begin n_err++; $display("FAIL b2b_writes: got %0d expected 2", wr_sel.size()); end
        if (done_cnt !== 1)      begin n_err++; $display("FAIL b2b_done: got %0d expected 1", done_cnt); end
        for (int i = 0; i < 2 && i < wr_sel.size(); i++) begin
            n_cmp += 2;
            if (wr_sel[i] !== 5'(3 + i)) begin n_err++; $display("FAIL b2b_sel[%0d]: got %0d expected %0d", i, wr_sel[i], 3 + i); end
            if (wr_data[i] !== seq_line(16 * i)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, wr_data[i], seq_line(16 * i)); end
        end
    endtask

    task automatic test_wrap();
        logic [4:0] exp_sel[3];
        exp_sel[0] = 5'd30;
        exp_sel[1] = 5'd31;
        exp_sel[2] = 5'd0;
        clear_log();
        launch(5'd30, 6'd3);
        stream(256, 48, 1'b0, -1, 1'b0);
        wait_idle();
        n_cmp += 2;
        if (wr_sel.size() !== 3) begin n_err++; $display("FAIL wrap_writes: got %0d expected 3", wr_sel.size()); end
        if (done_cnt !== 1)      begin n_err++; $display("FAIL wrap_done: got %0d expected 1", done_cnt); end
        for (int i = 0; i < 3 && i < wr_sel.size(); i++) begin
            n_cmp += 2;
            if (wr_sel[i] !== exp_sel[i]) begin n_err++; $display("FAIL wrap_sel[%0d]: got %0d expected %0d", i, wr_sel[i], exp_sel[i]); end
            if (wr_data[i] !== seq_line(256 + 16 * i)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, wr_data[i], seq_line(256 + 16 * i)); end
        end
    endtask

    task automatic test_zero_lines();
        clear_log();
        launch(5'd9, 6'd0);
        n_cmp += 3;
        if (bus.o_done !== 1'b1)     begin n_err++; $display("FAIL zero_done_pulse: got %b expected 1", bus.o_done); end
        if (bus.o_busy !== 1'b1)     begin n_err++; $display("FAIL zero_busy_in_done: got %b expected 1", bus.o_busy); end
        if (bus.o_s_ready !== 1'b0)  begin n_err++; $display("FAIL zero_s_ready: got %b expected 0", bus.o_s_ready); end
        tick();
        n_cmp += 3;
        if (bus.o_done !== 1'b0)     begin n_err++; $display("FAIL zero_done_end: got %b expected 0", bus.o_done); end
        if (bus.o_busy !== 1'b0)     begin n_err++; $display("FAIL zero_idle: got %b expected 0", bus.o_busy); end
        if (wr_sel.size() !== 0)     begin n_err++; $display("FAIL zero_writes: got %0d expected 0", wr_sel.size()); end
    endtask

    task automatic test_toggle_and_start();
        clear_log();
        launch(5'd7, 6'd1);
        stream(100, 16, 1'b1, -1, 1'b1);
        wait_idle();
        repeat (4) tick();
        n_cmp += 3;
        if (wr_sel.size() !== 1) begin n_err++; $display("FAIL toggle_writes: got %0d expected 1", wr_sel.size()); end
        if (done_cnt !== 1)      begin n_err++; $display("FAIL toggle_done: got %0d expected 1", done_cnt); end
        if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL toggle_stray_start: busy=%b expected 0", bus.o_busy); end
        if (wr_sel.size() > 0) begin
            n_cmp += 2;
            if (wr_sel[0] !== 5'd7) begin n_err++; $display("FAIL toggle_sel: got %0d expected 7", wr_sel[0]); end
            if (wr_data[0] !== seq_line(100)) begin n_err++; $display("FAIL toggle_data: got %h expected %h", wr_data[0], seq_line(100)); end
        end
    endtask

    task automatic test_s_last();
        logic [511:0] exp1;
        clear_log();
        exp1 = '0;
        for (int k = 0; k < 4; k++) exp1[32*k +: 32] = 32'(16 + k);
        if (PAD) begin
            launch(5'd12, 6'd4);
            stream(0, 20, 1'b0, 19, 1'b0);
            wait_idle();
            n_cmp += 2;
            if (wr_sel.size() !== 2) begin n_err++; $display("FAIL pad_writes: got %0d expected 2", wr_sel.size()); end
            if (done_cnt !== 1)      begin n_err++; $display("FAIL pad_done: got %0d expected 1", done_cnt); end
            if (wr_sel.size() == 2) begin
                n_cmp += 3;
                if (wr_data[0] !== seq_line(0)) begin n_err++; $display("FAIL pad_line0: got %h expected %h", wr_data[0], seq_line(0)); end
                if (wr_sel[1] !== 5'd13) begin n_err++; $display("FAIL pad_sel1: got %0d expected 13", wr_sel[1]); end
                if (wr_data[1] !== exp1) begin n_err++; $display("FAIL pad_line1: got %h expected %h", wr_data[1], exp1); end
            end
        end else begin
            launch(5'd12, 6'd1);
            stream(0, 16, 1'b0, 5, 1'b0);
            wait_idle();
            n_cmp += 2;
            if (wr_sel.size() !== 1) begin n_err++; $display("FAIL nopad_writes: got %0d expected 1", wr_sel.size()); end
            if (done_cnt !== 1)      begin n_err++; $display("FAIL nopad_done: got %0d expected 1", done_cnt); end
            if (wr_sel.size() == 1) begin
                n_cmp++;
                if (wr_data[0] !== seq_line(0)) begin n_err++; $display("FAIL nopad_line: got %h expected %h", wr_data[0], seq_line(0)); end
            end
        end
    endtask

    task automatic test_saturate();
        clear_log();
        launch(5'd5, 6'd40);
        stream(1000, 512, 1'b0, -1, 1'b0);
        wait_idle();
        n_cmp += 2;
        if (wr_sel.size() !== 32) begin n_err++; $display("FAIL sat_writes: got %0d expected 32", wr_sel.size()); end
        if (done_cnt !== 1)       begin n_err++; $display("FAIL sat_done: got %0d expected 1", done_cnt); end
        if (wr_sel.size() == 32) begin
            n_cmp += 2;
            if (wr_sel[31] !== 5'd4) begin n_err++; $display("FAIL sat_last_sel: got %0d expected 4", wr_sel[31]); end
            if (wr_data[31] !== seq_line(1000 + 496)) begin n_err++; $display("FAIL sat_last_data: got %h expected %h", wr_data[31], seq_line(1496)); end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        launch(5'd2, 6'd2);
        stream(0, 5, 1'b0, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (bus.o_busy !== 1'b0)     begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", bus.o_busy); end
        if (bus.o_s_ready !== 1'b0)  begin n_err++; $display("FAIL rstmid_s_ready: got %b expected 0", bus.o_s_ready); end
        if (bus.o_write_en !== 1'b0) begin n_err++; $display("FAIL rstmid_write_en: got %b expected 0", bus.o_write_en); end
        if (bus.o_line_data !== '0)  begin n_err++; $display("FAIL rstmid_line_data: got %h expected 0", bus.o_line_data); end
        bus.i_s_valid = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        bus.i_s_valid = 1'b0;
        n_cmp += 3;
        if (wr_sel.size() !== 0) begin n_err++; $display("FAIL rstmid_writes: got %0d expected 0", wr_sel.size()); end
        if (done_cnt !== 0)      begin n_err++; $display("FAIL rstmid_done: got %0d expected 0", done_cnt); end
        if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_stays_idle: got %b expected 0", bus.o_busy); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_zero_lines();
        test_toggle_and_start();
        test_s_last();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
